// File: rtl/display_source_arbiter.sv
// Registered priority arbiter for the seven-segment display mux.
// Grants hold for a minimum dwell time and fall back to a default source.
module display_source_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1,
    parameter int DEFAULT_SRC = 2,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter bit PREEMPT     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic               active,
    output logic               sel_change,
    output logic               hold_done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SEL_W-1:0] DEF  = SEL_W'(DEFAULT_SRC);
    localparam logic [CW-1:0]    LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic [NUM_SRC-1:0] eff_req;
    logic [SEL_W-1:0]   top;
    logic               any;

    // Ascending scan: the last set bit seen is the highest priority.
    always_comb begin
        eff_req              = req;
        eff_req[DEFAULT_SRC] = 1'b0;
        any                  = |eff_req;
        top                  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eff_req[i]) top = SEL_W'(i);
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (any) begin
                    sel_d   = top;
                    cnt_d   = LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    if (PREEMPT && (top > sel)) begin
                        sel_d = top;
                        cnt_d = LOAD;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end else if (eff_req[sel] && (top == sel)) begin
                    cnt_d = '0;
                end else if (any) begin
                    sel_d = top;
                    cnt_d = LOAD;
                end else begin
                    sel_d   = DEF;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = DEF;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags are derived from next-state values so they stay aligned with sel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= DEF;
            cnt        <= '0;
            active     <= 1'b0;
            sel_change <= 1'b0;
            hold_done  <= 1'b1;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            cnt        <= cnt_d;
            active     <= (sel_d != DEF);
            sel_change <= (sel_d != sel);
            hold_done  <= (cnt_d == '0);
        end
    end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Randomised and directed bench for display_source_arbiter.
// Two instances (pre-emptive and non-pre-emptive) share one stimulus stream.
module tb_display_source_arbiter;

    localparam int HOLD = 4;
    localparam int DEFS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [1:0] sel0, sel1;
    logic       act0, act1, chg0, chg1, hd0, hd1;

    int total = 0;
    int bad = 0;

    int msel[2];
    int mleft[2];
    bit mchg[2];
    bit pre[2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    display_source_arbiter #(
        .NUM_SRC(4), .DEFAULT_SRC(DEFS), .HOLD_CYCLES(HOLD), .PREEMPT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel(sel0), .active(act0), .sel_change(chg0), .hold_done(hd0)
    );

    display_source_arbiter #(
        .NUM_SRC(4), .DEFAULT_SRC(DEFS), .HOLD_CYCLES(HOLD), .PREEMPT(1'b0)
    ) dut_np (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel(sel1), .active(act1), .sel_change(chg1), .hold_done(hd1)
    );

    // Highest requesting source, default source ignored; -1 when nobody asks.
    function automatic int winner(logic [3:0] r);
        for (int i = 3; i >= 0; i--) begin
            if (i != DEFS && r[i]) return i;
        end
        return -1;
    endfunction

    // Reference: "shown source" plus "cycles left before it may be released".
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            int w;
            int ns;
            int nl;
            if (!rst_n) begin
                msel[p]  = DEFS;
                mleft[p] = 0;
                mchg[p]  = 1'b0;
            end else begin
                w  = winner(req);
                ns = msel[p];
                nl = mleft[p];
                if (msel[p] == DEFS) begin
                    if (w >= 0) begin
                        ns = w;
                        nl = HOLD - 1;
                    end
                end else if (mleft[p] > 0) begin
                    if (pre[p] && w > msel[p]) begin
                        ns = w;
                        nl = HOLD - 1;
                    end else begin
                        nl = mleft[p] - 1;
                    end
                end else if (w != msel[p]) begin
                    ns = (w >= 0) ? w : DEFS;
                    nl = (w >= 0) ? HOLD - 1 : 0;
                end
                mchg[p]  = (ns != msel[p]);
                msel[p]  = ns;
                mleft[p] = nl;
            end
        end
    end

    function automatic logic [4:0] obs(int p);
        if (p == 0) return {sel0, act0, chg0, hd0};
        return {sel1, act1, chg1, hd1};
    endfunction

    function automatic logic [4:0] expv(int p);
        return {2'(msel[p]), msel[p] != DEFS, mchg[p], mleft[p] == 0};
    endfunction

    task automatic tick(input logic [3:0] r, input logic rn = 1'b1);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int c = 0; c < 6; c++) tick(4'b0000);
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b0);
        total++;
        if ({sel0, act0, chg0, hd0} !== 5'b10_0_0_1) begin
            bad++;
            $display("FAIL reset got=%b want=10001", {sel0, act0, chg0, hd0});
        end
        for (int c = 0; c < 10; c++) begin
            tick(4'b0000);
            for (int p = 0; p < 2; p++) begin
                total++;
                if (obs(p) !== expv(p) || obs(p) !== 5'b10001) begin
                    bad++;
                    $display("FAIL idle[%0d] c%0d got=%b want=%b", p, c, obs(p), expv(p));
                end
            end
        end
    endtask

    task automatic test_pulse();
        settle();
        tick(4'b0001);
        total++;
        if (sel0 !== 2'd0 || chg0 !== 1'b1 || act0 !== 1'b1) begin
            bad++;
            $display("FAIL pulse_grant got sel=%0d chg=%b want sel=0 chg=1", sel0, chg0);
        end
        for (int c = 0; c < 4; c++) begin
            tick(4'b0000);
            for (int p = 0; p < 2; p++) begin
                total++;
                if (obs(p) !== expv(p)) begin
                    bad++;
                    $display("FAIL pulse[%0d] c%0d got=%b want=%b", p, c, obs(p), expv(p));
                end
            end
        end
        total++;
        if (sel0 !== 2'd2 || chg0 !== 1'b1 || act0 !== 1'b0) begin
            bad++;
            $display("FAIL pulse_release got sel=%0d chg=%b want sel=2 chg=1", sel0, chg0);
        end
    endtask

    task automatic test_preempt();
        settle();
        tick(4'b0010);
        tick(4'b0010);
        tick(4'b1010);
        total++;
        if (sel0 !== 2'd3 || chg0 !== 1'b1 || hd0 !== 1'b0 || sel1 !== 2'd1) begin
            bad++;
            $display("FAIL preempt got sel=%0d/%0d want 3/1", sel0, sel1);
        end
        for (int c = 0; c < 8; c++) begin
            tick(4'b1010);
            for (int p = 0; p < 2; p++) begin
                total++;
                if (obs(p) !== expv(p)) begin
                    bad++;
                    $display("FAIL preempt[%0d] c%0d got=%b want=%b", p, c, obs(p), expv(p));
                end
            end
        end
    endtask

    task automatic test_expiry_lower();
        settle();
        tick(4'b1000);
        for (int c = 0; c < 3; c++) tick(4'b0001);
        total++;
        if (sel0 !== 2'd3 || hd0 !== 1'b1) begin
            bad++;
            $display("FAIL expiry_pre got sel=%0d hd=%b want sel=3 hd=1", sel0, hd0);
        end
        tick(4'b0001);
        total++;
        if (sel0 !== 2'd0 || chg0 !== 1'b1) begin
            bad++;
            $display("FAIL expiry_lower got sel=%0d chg=%b want sel=0 chg=1", sel0, chg0);
        end
        settle();
        tick(4'b1011);
        total++;
        if (sel0 !== 2'd3 || sel1 !== 2'd3) begin
            bad++;
            $display("FAIL simultaneous got sel=%0d/%0d want 3/3", sel0, sel1);
        end
    endtask

    task automatic test_default_and_long();
        int chgs;
        int hds;
        settle();
        for (int c = 0; c < 5; c++) begin
            tick(4'b0100);
            total++;
            if (sel0 !== 2'd2 || chg0 !== 1'b0 || act0 !== 1'b0) begin
                bad++;
                $display("FAIL default_only c%0d got sel=%0d chg=%b", c, sel0, chg0);
            end
        end
        chgs = 0;
        hds  = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(4'b0010);
            chgs += int'(chg0);
            if (c >= 4) hds += int'(hd0);
            total++;
            if (sel0 !== 2'd1 || hd0 !== (c >= 4)) begin
                bad++;
                $display("FAIL long_hold c%0d got sel=%0d hd=%b want sel=1 hd=%b", c, sel0, hd0, c >= 4);
            end
        end
        total++;
        if (chgs !== 1 || hds !== 17) begin
            bad++;
            $display("FAIL long_counts got chg=%0d hd=%0d want chg=1 hd=17", chgs, hds);
        end
    endtask

    task automatic test_reset_mid_hold();
        settle();
        tick(4'b1000);
        tick(4'b1000);
        tick(4'b1000, 1'b0);
        total++;
        if (sel0 !== 2'd2 || act0 !== 1'b0 || hd0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got sel=%0d act=%b hd=%b want 2/0/1", sel0, act0, hd0);
        end
        tick(4'b1000);
        total++;
        if (sel0 !== 2'd3 || chg0 !== 1'b1) begin
            bad++;
            $display("FAIL after_reset got sel=%0d chg=%b want sel=3 chg=1", sel0, chg0);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rn;
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            rn = ($urandom_range(0, 79) != 0);
            tick(r, rn);
            for (int p = 0; p < 2; p++) begin
                total++;
                if (obs(p) !== expv(p)) begin
                    bad++;
                    $display("FAIL random[%0d] c%0d req=%b got=%b want=%b", p, c, r, obs(p), expv(p));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_preempt();
        test_expiry_lower();
        test_default_and_long();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
